// File: rtl/lsu_wb.sv
// lsu_wb: load/store and write-back stage driving the register file write port
module lsu_wb (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        ex_wen,
  input  logic [4:0]  ex_waddr,
  input  logic [31:0] ex_wdata,
  input  logic [3:0]  ex_memop,
  input  logic [31:0] ex_maddr,
  input  logic [31:0] ex_sdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wen,
  output logic [4:0]  waddr,
  output logic [31:0] wdata,
  output logic        addr_err
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q, state_d;
  logic [3:0] op_q, op_d;
  logic [1:0] off_q, off_d;
  logic [4:0] dst_q, dst_d;
  logic dwen_q, dwen_d;
  logic mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [3:0] mem_be_q, mem_be_d;
  logic wen_q, wen_d, addr_err_q, addr_err_d;
  logic [4:0] waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic is_byte, is_half, is_word, is_st, is_mem, mis;
  logic [31:0] sh, ldv;
  assign ex_ready  = (state_q == IDLE) && !rst;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign wen       = wen_q;
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;
  assign addr_err  = addr_err_q;
  always_comb begin
    is_byte = ex_memop == 4'd1 || ex_memop == 4'd2 || ex_memop == 4'd6;
    is_half = ex_memop == 4'd3 || ex_memop == 4'd4 || ex_memop == 4'd7;
    is_word = ex_memop == 4'd5 || ex_memop == 4'd8;
    is_st   = ex_memop == 4'd6 || ex_memop == 4'd7 || ex_memop == 4'd8;
    is_mem  = is_byte || is_half || is_word;
    mis     = (is_half && ex_maddr[0]) || (is_word && ex_maddr[1:0] != 2'b00);
    // shift the addressed lane to the top so extraction is offset-independent
    sh  = mem_rdata << {off_q, 3'b000};
    ldv = op_q == 4'd1 ? {{24{sh[31]}}, sh[31:24]} :
          op_q == 4'd2 ? {24'd0, sh[31:24]} :
          op_q == 4'd3 ? {{16{sh[31]}}, sh[31:16]} :
          op_q == 4'd4 ? {16'd0, sh[31:16]} : mem_rdata;
    state_d     = state_q;
    op_d        = op_q;
    off_d       = off_q;
    dst_d       = dst_q;
    dwen_d      = dwen_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    wen_d       = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    addr_err_d  = 1'b0;
    if (state_q == IDLE && ex_valid && ex_ready) begin
      if (!is_mem) begin
        wen_d   = ex_wen && ex_waddr != 5'd0;
        waddr_d = ex_waddr;
        wdata_d = ex_wdata;
      end else if (mis) begin
        addr_err_d = 1'b1;
      end else begin
        state_d     = BUSY;
        op_d        = ex_memop;
        off_d       = ex_maddr[1:0];
        dst_d       = ex_waddr;
        dwen_d      = ex_wen && !is_st;
        mem_req_d   = 1'b1;
        mem_we_d    = is_st;
        mem_addr_d  = {ex_maddr[31:2], 2'b00};
        mem_be_d    = is_byte ? 4'b1000 >> ex_maddr[1:0] :
                      is_half ? (ex_maddr[1] ? 4'b0011 : 4'b1100) : 4'b1111;
        mem_wdata_d = is_byte ? {4{ex_sdata[7:0]}} :
                      is_half ? {2{ex_sdata[15:0]}} : ex_sdata;
      end
    end else if (state_q == BUSY && mem_ack) begin
      state_d   = IDLE;
      mem_req_d = 1'b0;
      wen_d     = dwen_q && dst_q != 5'd0;
      waddr_d   = dst_q;
      wdata_d   = ldv;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= 4'd0;
      off_q       <= 2'd0;
      dst_q       <= 5'd0;
      dwen_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_be_q    <= 4'd0;
      mem_wdata_q <= 32'd0;
      wen_q       <= 1'b0;
      waddr_q     <= 5'd0;
      wdata_q     <= 32'd0;
      addr_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      off_q       <= off_d;
      dst_q       <= dst_d;
      dwen_q      <= dwen_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      wen_q       <= wen_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      addr_err_q  <= addr_err_d;
    end
  end
endmodule

// File: tb/tb_lsu_wb.sv
// tb_lsu_wb: scoreboard bench for lsu_wb against a byte-addressed memory model
module tb_lsu_wb;
  logic clk = 0, rst = 1;
  logic ex_valid = 0, ex_wen = 0;
  logic [4:0] ex_waddr = 0;
  logic [31:0] ex_wdata = 0, ex_maddr = 0, ex_sdata = 0;
  logic [3:0] ex_memop = 0;
  logic ex_ready, mem_req, mem_we, mem_ack, wen, addr_err;
  logic [31:0] mem_addr, mem_wdata, wdata;
  logic [31:0] mem_rdata = 0;
  logic [3:0] mem_be;
  logic [4:0] waddr;
  logic resp_ack = 0, late_ack = 0, ack_en = 1;
  int fix_dly = -1, cyc = 0, ack_cyc = 0, acc_cyc = 0, tests = 0, fails = 0, ecnt = 0;

  typedef struct {logic [4:0] a; logic [31:0] d; bit ld; int due;} wexp_t;
  typedef struct {logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wd;} bexp_t;
  wexp_t wq[$];
  bexp_t bq[$];
  logic [7:0] mm[int unsigned];
  logic [7:0] rm[int unsigned];

  assign mem_ack = resp_ack | late_ack;

  lsu_wb dut (.clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_wen(ex_wen),
    .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_memop(ex_memop), .ex_maddr(ex_maddr),
    .ex_sdata(ex_sdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .wen(wen), .waddr(waddr),
    .wdata(wdata), .addr_err(addr_err));

  always #5 clk = ~clk;
  initial forever @(posedge clk) cyc++;

  function automatic logic [7:0] init_byte(input int unsigned a);
    logic [7:0] t = a[7:0];
    return (t * 8'd37) ^ 8'hA5;
  endfunction
  function automatic logic [7:0] mbyte(input int unsigned a);
    return mm.exists(a) ? mm[a] : init_byte(a);
  endfunction
  function automatic logic [7:0] rbyte(input int unsigned a);
    return rm.exists(a) ? rm[a] : init_byte(a);
  endfunction

  task automatic poke(input int unsigned a, input logic [31:0] w);
    for (int j = 0; j < 4; j++) begin
      mm[a + j] = w[31 - 8 * j -: 8];
      rm[a + j] = w[31 - 8 * j -: 8];
    end
  endtask

  task automatic model(input logic [3:0] op, input logic w, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [31:0] ma, input logic [31:0] sd);
    int sz = (op == 1 || op == 2 || op == 6) ? 1 : (op == 3 || op == 4 || op == 7) ? 2 :
             (op == 5 || op == 8) ? 4 : 0;
    int off;
    logic [3:0] be;
    logic [31:0] v, wdx;
    if (sz == 0) begin
      if (w && wa != 0) wq.push_back('{wa, wd, 1'b0, cyc + 1});
      return;
    end
    if (ma % sz != 0) begin
      ecnt++;
      return;
    end
    off = int'(ma % 4);
    be = 0;
    for (int k = off; k < off + sz; k++) be[3 - k] = 1'b1;
    wdx = sz == 1 ? {4{sd[7:0]}} : sz == 2 ? {2{sd[15:0]}} : sd;
    bq.push_back('{op >= 6, ma & ~32'd3, be, wdx});
    if (op >= 6) begin
      for (int j = 0; j < sz; j++) mm[ma + j] = sd[8 * (sz - 1 - j) +: 8];
    end else begin
      v = 0;
      for (int j = 0; j < sz; j++) v = (v << 8) | {24'd0, mbyte(ma + j)};
      if (op == 1) v = {{24{v[7]}}, v[7:0]};
      if (op == 3) v = {{16{v[15]}}, v[15:0]};
      if (w && wa != 0) wq.push_back('{wa, v, 1'b1, 0});
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic w, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [31:0] ma, input logic [31:0] sd);
    int n = 0;
    @(negedge clk);
    ex_valid = 1; ex_memop = op; ex_wen = w; ex_waddr = wa;
    ex_wdata = wd; ex_maddr = ma; ex_sdata = sd;
    while (!ex_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (!ex_ready) begin
      fails++;
      $display("FAIL accept_timeout: ex_ready=%b after %0d cycles, required 1", ex_ready, n);
      ex_valid = 0;
      return;
    end
    acc_cyc = cyc;
    model(op, w, wa, wd, ma, sd);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    ex_valid = 0;
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    check(nm, {mem_req, mem_we, mem_be, wen, addr_err, waddr, ex_ready}, 64'd0);
    check({nm, "_data"}, {mem_addr, mem_wdata ^ wdata}, 64'd0);
    check({nm, "_wdata"}, {32'd0, wdata}, 64'd0);
  endtask

  // memory responder: random or fixed ack delay, keeps its own byte memory
  initial begin
    int dly = 0;
    bit in_req = 0;
    forever begin
      @(negedge clk);
      resp_ack = 0;
      if (mem_req && ack_en && !rst) begin
        if (!in_req) begin
          in_req = 1;
          dly = fix_dly >= 0 ? fix_dly : int'($urandom_range(0, 3));
        end
        if (dly == 0) begin
          resp_ack = 1;
          ack_cyc = cyc;
          in_req = 0;
          mem_rdata = {rbyte(mem_addr), rbyte(mem_addr + 1), rbyte(mem_addr + 2), rbyte(mem_addr + 3)};
          if (mem_we)
            for (int i = 0; i < 4; i++) if (mem_be[3 - i]) rm[mem_addr + i] = mem_wdata[31 - 8 * i -: 8];
        end else dly--;
      end else if (!mem_req) in_req = 0;
    end
  end

  // monitor: pops expectations whenever the DUT presents a result or bus request
  initial begin
    bit req_prev = 0;
    bexp_t cur;
    wexp_t e;
    int due;
    forever begin
      @(negedge clk);
      if (rst) req_prev = 0;
      else begin
        if (wen) begin
          tests++;
          if (wq.size() == 0) begin
            fails++;
            $display("FAIL unexpected_wen: waddr=%0d wdata=%h, required no write", waddr, wdata);
          end else begin
            e = wq.pop_front();
            due = e.ld ? ack_cyc + 1 : e.due;
            if (waddr !== e.a || wdata !== e.d || cyc != due) begin
              fails++;
              $display("FAIL wb: waddr=%0d wdata=%h cyc=%0d, required waddr=%0d wdata=%h cyc=%0d",
                       waddr, wdata, cyc, e.a, e.d, due);
            end
          end
        end
        if (addr_err) begin
          tests++;
          if (ecnt == 0) begin
            fails++;
            $display("FAIL unexpected_addr_err: addr_err=1, required 0");
          end else ecnt--;
        end
        if (mem_req) begin
          tests++;
          if (ex_ready !== 1'b0) begin
            fails++;
            $display("FAIL busy_ready: ex_ready=%b, required 0", ex_ready);
          end
          tests++;
          if (!req_prev) begin
            if (bq.size() == 0) begin
              fails++;
              $display("FAIL unexpected_req: addr=%h be=%b we=%b, required no request", mem_addr, mem_be, mem_we);
            end else begin
              cur = bq.pop_front();
              if (mem_we !== cur.we || mem_addr !== cur.addr || mem_be !== cur.be ||
                  (cur.we && mem_wdata !== cur.wd)) begin
                fails++;
                $display("FAIL bus: we=%b addr=%h be=%b wdata=%h, required we=%b addr=%h be=%b wdata=%h",
                         mem_we, mem_addr, mem_be, mem_wdata, cur.we, cur.addr, cur.be, cur.wd);
              end
              cur = '{mem_we, mem_addr, mem_be, mem_wdata};
            end
          end else if (mem_we !== cur.we || mem_addr !== cur.addr || mem_be !== cur.be || mem_wdata !== cur.wd) begin
            fails++;
            $display("FAIL bus_stable: we=%b addr=%h be=%b wdata=%h, required held we=%b addr=%h be=%b wdata=%h",
                     mem_we, mem_addr, mem_be, mem_wdata, cur.we, cur.addr, cur.be, cur.wd);
          end
        end
        req_prev = mem_req;
      end
    end
  end

  initial begin
    int b2b;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    rst = 0;
    issue(4'd0, 1, 5'd5, 32'h1234_5678, 0, 0);
    issue(4'd0, 1, 5'd0, 32'hDEAD_BEEF, 0, 0);
    idle(2);
    poke(32'h100, 32'h11F2_3344);
    fix_dly = 3;
    issue(4'd1, 1, 5'd7, 0, 32'h101, 0);
    issue(4'd2, 1, 5'd8, 0, 32'h101, 0);
    issue(4'd7, 1, 5'd9, 0, 32'h202, 32'hAAAA_BEEF);
    issue(4'd5, 1, 5'd10, 0, 32'h103, 0);
    idle(4);
    ack_en = 0;
    issue(4'd5, 1, 5'd11, 0, 32'h108, 0);
    idle(2);
    rst = 1;
    wq.delete();
    #1 check("reset_ready", {63'd0, ex_ready}, 64'd0);
    @(negedge clk);
    check_reset_outputs("abort_reset");
    rst = 0;
    ack_en = 1;
    late_ack = 1;
    @(negedge clk);
    late_ack = 0;
    idle(3);
    fix_dly = 0;
    issue(4'd5, 1, 5'd3, 0, 32'h100, 0);
    b2b = acc_cyc;
    issue(4'd0, 1, 5'd4, 32'hCAFE_0004, 0, 0);
    check("b2b_accept", 64'(acc_cyc - b2b), 64'd2);
    fix_dly = -1;
    for (int i = 0; i < 300; i++) begin
      issue(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            $urandom, 32'h100 + $urandom_range(0, 31), $urandom);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 2));
    end
    idle(12);
    check("wq_drained", 64'(wq.size()), 64'd0);
    check("bq_drained", 64'(bq.size()), 64'd0);
    check("err_drained", 64'(ecnt), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
